fifo_write_ctrl: RTL and testbench

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_sync_2ff.sv | 26 ++
 rtl/fifo_write_ctrl.sv | 85 ++++++++
 tb/tb_fifo_write_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths and Gray/binary pointer conversions.
// The conversions work on a wide word so any pointer width up to 32 bits can
// zero-extend into them and truncate the result back with a size cast.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 4;
    localparam int PTR_WORD_WIDTH        = 32;

    typedef logic [PTR_WORD_WIDTH-1:0] ptr_word_t;

    // Binary to reflected Gray code; zero upper bits stay zero.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary as a running XOR from the MSB down; zero upper bits
    // contribute nothing, so a zero-extended narrow pointer converts correctly.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_WORD_WIDTH-1] = gray[PTR_WORD_WIDTH-1];
        for (int i = PTR_WORD_WIDTH-2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for bringing a Gray-coded pointer across clock domains.
// Shared by both sides of the FIFO; the first stage may go metastable, the
// second gives it a full cycle to resolve.
module fifo_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an asynchronous FIFO with external storage.
// Keeps the binary/Gray write pointers, synchronizes the read pointer into
// wclk, and produces registered full, almost-full, level and overflow flags.
// ADDRESS_WIDTH must be at least 2 for the full comparison to be meaningful.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                   wclk,
    input  logic                   hw_rst_n,
    input  logic                   write_enable,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic [ADDRESS_WIDTH-1:0] afull_value,
    input  logic [ADDRESS_WIDTH:0] rd_gray_ptr,
    output logic [ADDRESS_WIDTH:0] wr_gray_ptr,
    output logic                   mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   wrfull,
    output logic                   wr_almost_full,
    output logic                   overflow,
    output logic [ADDRESS_WIDTH:0] fifo_write_count,
    output logic [ADDRESS_WIDTH:0] wr_level
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int PW = ADDRESS_WIDTH + 1;

    logic [AW:0] wptr_bin;
    logic [AW:0] wptr_next;
    logic [AW:0] gray_next;
    logic [AW:0] rsync;
    logic [AW:0] rptr_sync_bin;
    logic [AW:0] level_next;
    logic [AW:0] full_pattern;
    logic        accept;

    fifo_sync_2ff #(
        .WIDTH(PW)
    ) u_rd_sync (
        .clk  (wclk),
        .rst_n(hw_rst_n),
        .d    (rd_gray_ptr),
        .q    (rsync)
    );

    // Writes are accepted only when not full and not held in reset, so a
    // write overlapping reset never strobes the storage.
    always_comb begin
        accept        = write_enable && !wrfull && hw_rst_n;
        wptr_next     = wptr_bin + PW'(accept);
        gray_next     = PW'(bin2gray(ptr_word_t'(wptr_next)));
        rptr_sync_bin = PW'(gray2bin(ptr_word_t'(rsync)));
        level_next    = wptr_next - rptr_sync_bin;
        full_pattern  = {~rsync[AW:AW-1], rsync[AW-2:0]};
    end

    assign mem_we           = accept;
    assign mem_waddr        = wptr_bin[AW-1:0];
    assign mem_wdata        = write_data;
    assign fifo_write_count = wptr_bin;

    // Pointer and flag registers all look at the post-write pointer so the
    // flags describe the FIFO as it stands after this edge.
    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            wptr_bin       <= '0;
            wr_gray_ptr    <= '0;
            wrfull         <= 1'b0;
            wr_almost_full <= 1'b0;
            overflow       <= 1'b0;
            wr_level       <= '0;
        end else begin
            wptr_bin       <= wptr_next;
            wr_gray_ptr    <= gray_next;
            wrfull         <= (gray_next == full_pattern);
            wr_almost_full <= (level_next >= {1'b0, afull_value});
            overflow       <= write_enable && wrfull;
            wr_level       <= level_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl (ADDRESS_WIDTH=4, DATA_WIDTH=8).
// The reference model tracks total accepted writes and total reads as plain
// integers; occupancy is their difference and full means occupancy == depth.
module tb_fifo_write_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    logic          wclk = 1'b0;
    logic          hw_rst_n;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic [AW-1:0] afull_value;
    logic [AW:0]   rd_gray_ptr;
    logic [AW:0]   wr_gray_ptr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wrfull;
    logic          wr_almost_full;
    logic          overflow;
    logic [AW:0]   fifo_write_count;
    logic [AW:0]   wr_level;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int   m_total;
    int   rd_total;
    int   rd_seen1;
    int   rd_seen2;
    bit   m_full;
    bit   m_afull;
    bit   m_ovf;
    int   m_level;
    logic [AW:0] prev_gray;

    fifo_write_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .wclk            (wclk),
        .hw_rst_n        (hw_rst_n),
        .write_enable    (write_enable),
        .write_data      (write_data),
        .afull_value     (afull_value),
        .rd_gray_ptr     (rd_gray_ptr),
        .wr_gray_ptr     (wr_gray_ptr),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .wrfull          (wrfull),
        .wr_almost_full  (wr_almost_full),
        .overflow        (overflow),
        .fifo_write_count(fifo_write_count),
        .wr_level        (wr_level)
    );

    always #5 wclk = ~wclk;

    function automatic logic [AW:0] to_gray(input int count);
        int v;
        v = count % PMOD;
        return 5'(v ^ (v >> 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkRegistered();
        checkOutput("wrfull",      32'(wrfull),           32'(m_full));
        checkOutput("almost_full", 32'(wr_almost_full),   32'(m_afull));
        checkOutput("overflow",    32'(overflow),         32'(m_ovf));
        checkOutput("wr_level",    32'(wr_level),         32'(m_level));
        checkOutput("write_count", 32'(fifo_write_count), 32'(m_total % PMOD));
        checkOutput("wr_gray_ptr", 32'(wr_gray_ptr),      32'(to_gray(m_total)));
        checkOutput("gray_step",   32'($countones(wr_gray_ptr ^ prev_gray) <= 1), 32'd1);
        prev_gray = wr_gray_ptr;
    endtask

    task automatic resetModel();
        m_total   = 0;
        rd_total  = 0;
        rd_seen1  = 0;
        rd_seen2  = 0;
        m_full    = 1'b0;
        m_afull   = 1'b0;
        m_ovf     = 1'b0;
        m_level   = 0;
        prev_gray = '0;
    endtask

    // One wclk cycle: drive at the falling edge, check the combinational
    // write port, then advance the model at the rising edge and check flags.
    task automatic applyStimulus(input bit we, input logic [DW-1:0] data, input bit rd_adv);
        bit accept;
        int rs;
        @(negedge wclk);
        if (rd_adv && rd_total < m_total) rd_total++;
        write_enable = we;
        write_data   = data;
        rd_gray_ptr  = to_gray(rd_total);
        #1;
        accept = we && !m_full;
        checkOutput("mem_we", 32'(mem_we), 32'(accept));
        if (accept) begin
            checkOutput("mem_waddr", 32'(mem_waddr), 32'(m_total % DEPTH));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(data));
        end
        @(posedge wclk);
        rs       = rd_seen2;
        m_ovf    = we && m_full;
        m_total  = m_total + int'(accept);
        m_level  = (m_total - rs) % PMOD;
        m_full   = (m_level == DEPTH);
        m_afull  = (m_level >= int'(afull_value));
        rd_seen2 = rd_seen1;
        rd_seen1 = rd_total;
        #1;
        checkRegistered();
    endtask

    // Drop reset between edges while a write is being requested; every
    // registered output and the write strobe must clear at once.
    task automatic pulseReset();
        @(negedge wclk);
        write_enable = 1'b1;
        rd_gray_ptr  = '0;
        hw_rst_n     = 1'b0;
        #1;
        resetModel();
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkRegistered();
        @(posedge wclk);
        #1;
        checkRegistered();
        @(negedge wclk);
        write_enable = 1'b0;
        hw_rst_n     = 1'b1;
    endtask

    initial begin
        hw_rst_n     = 1'b0;
        write_enable = 1'b0;
        write_data   = '0;
        afull_value  = 4'd12;
        rd_gray_ptr  = '0;
        resetModel();
        #2;
        checkRegistered();
        pulseReset();

        // Fill sixteen entries with no reads
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            if (i == 10) checkOutput("afull_before_12", 32'(wr_almost_full), 32'd0);
            if (i == 11) begin
                checkOutput("afull_at_12", 32'(wr_almost_full), 32'd1);
                checkOutput("level_at_12", 32'(wr_level), 32'd12);
            end
        end
        checkOutput("fill_full",  32'(wrfull),           32'd1);
        checkOutput("fill_level", 32'(wr_level),         32'd16);
        checkOutput("fill_count", 32'(fifo_write_count), 32'd16);

        // Two rejected writes while full
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0);
        checkOutput("ovf_held",  32'(overflow),         32'd1);
        checkOutput("ovf_count", 32'(fifo_write_count), 32'd16);

        // One read releases full within three edges; the write in the same
        // cycle as the read advance is still rejected
        applyStimulus(1'b1, 8'hCC, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("release_full",  32'(wrfull),   32'd0);
        checkOutput("release_level", 32'(wr_level), 32'd15);
        checkOutput("release_count", 32'(fifo_write_count), 32'd16);
        applyStimulus(1'b1, 8'h5A, 1'b0);

        // Randomized traffic: slow reader first so the FIFO fills, then a
        // faster reader so the pointers wrap repeatedly
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) afull_value = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 99) < 70, 8'($urandom),
                          $urandom_range(0, 99) < (i < 200 ? 30 : 85));
        end

        // Reset in the middle of a stream of writes
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
        pulseReset();
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput("post_reset_count", 32'(fifo_write_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
